// File: rtl/mvu_job_scheduler.sv
// Round-robin scheduler sharing one MVU among NREQ requesters: accept, write descriptor CSRs,
// start, wait for done or timeout, then return a tagged one-cycle completion.
module mvu_job_scheduler #(
  parameter int                NREQ      = 8,
  parameter int                CFG_WORDS = 4,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] CFG_BASE  = 'h40,
  parameter int                TMO_W     = 20
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREQ-1:0]                   req_valid,
  input  logic [NREQ*CFG_WORDS*DATA_W-1:0]  req_desc,
  output logic [NREQ-1:0]                   req_ready,
  output logic                              cfg_wr_en,
  output logic [ADDR_W-1:0]                 cfg_wr_addr,
  output logic [DATA_W-1:0]                 cfg_wr_data,
  output logic                              mvu_start,
  input  logic                              mvu_done,
  input  logic [TMO_W-1:0]                  tmo_cycles,
  output logic                              cpl_valid,
  output logic [$clog2(NREQ)-1:0]           cpl_id,
  output logic                              cpl_timeout,
  output logic                              busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int WCW = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
  localparam int DSW = CFG_WORDS * DATA_W;

  typedef enum logic [2:0] {IDLE, CFG, START, WAIT, CPL} state_t;

  state_t             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     id_q;
  logic [DSW-1:0]     desc_q;
  logic [WCW-1:0]     wcnt_q;
  logic [TMO_W-1:0]   tcnt_q;
  logic               cfg_wr_en_q;
  logic [ADDR_W-1:0]  cfg_wr_addr_q;
  logic [DATA_W-1:0]  cfg_wr_data_q;
  logic               mvu_start_q;
  logic               cpl_valid_q;
  logic [IDW-1:0]     cpl_id_q;
  logic               cpl_timeout_q;

  logic               gnt_vld;
  logic [IDW-1:0]     gnt_idx;
  logic [DSW-1:0]     gnt_desc;
  logic [WCW-1:0]     wcnt_d;
  logic [TMO_W-1:0]   tcnt_d;
  logic               expire;

  // Scan from the highest offset down so the nearest valid requester after ptr_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr_q) + k) % NREQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign gnt_desc = req_desc[int'(gnt_idx)*DSW +: DSW];
  assign wcnt_d   = wcnt_q + 1'b1;
  assign tcnt_d   = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
  assign expire   = (tmo_cycles != '0) && (tcnt_q == tmo_cycles - 1'b1);

  // rst_n gates the strobe directly so no job can be taken while reset is held.
  assign req_ready = (rst_n && state_q == IDLE && gnt_vld) ? (NREQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= IDW'(NREQ - 1);
      id_q          <= '0;
      desc_q        <= '0;
      wcnt_q        <= '0;
      tcnt_q        <= '0;
      cfg_wr_en_q   <= 1'b0;
      cfg_wr_addr_q <= '0;
      cfg_wr_data_q <= '0;
      mvu_start_q   <= 1'b0;
      cpl_valid_q   <= 1'b0;
      cpl_id_q      <= '0;
      cpl_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            state_q       <= CFG;
            ptr_q         <= gnt_idx;
            id_q          <= gnt_idx;
            desc_q        <= gnt_desc;
            wcnt_q        <= '0;
            cfg_wr_en_q   <= 1'b1;
            cfg_wr_addr_q <= CFG_BASE;
            cfg_wr_data_q <= gnt_desc[DATA_W-1:0];
          end
        end
        CFG: begin
          if (wcnt_q == WCW'(CFG_WORDS - 1)) begin
            state_q       <= START;
            cfg_wr_en_q   <= 1'b0;
            cfg_wr_addr_q <= '0;
            cfg_wr_data_q <= '0;
            mvu_start_q   <= 1'b1;
          end else begin
            wcnt_q        <= wcnt_d;
            cfg_wr_addr_q <= CFG_BASE + ADDR_W'(wcnt_d);
            cfg_wr_data_q <= desc_q[int'(wcnt_d)*DATA_W +: DATA_W];
          end
        end
        START: begin
          state_q     <= WAIT;
          mvu_start_q <= 1'b0;
          wcnt_q      <= '0;
          tcnt_q      <= '0;
        end
        WAIT: begin
          // done takes priority over a simultaneous expiry.
          if (mvu_done) begin
            state_q       <= CPL;
            cpl_valid_q   <= 1'b1;
            cpl_id_q      <= id_q;
            cpl_timeout_q <= 1'b0;
          end else if (expire) begin
            state_q       <= CPL;
            cpl_valid_q   <= 1'b1;
            cpl_id_q      <= id_q;
            cpl_timeout_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_d;
          end
        end
        CPL: begin
          state_q       <= IDLE;
          cpl_valid_q   <= 1'b0;
          cpl_id_q      <= '0;
          cpl_timeout_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_wr_en   = cfg_wr_en_q;
  assign cfg_wr_addr = cfg_wr_addr_q;
  assign cfg_wr_data = cfg_wr_data_q;
  assign mvu_start   = mvu_start_q;
  assign cpl_valid   = cpl_valid_q;
  assign cpl_id      = cpl_id_q;
  assign cpl_timeout = cpl_timeout_q;
  assign busy        = (state_q != IDLE);

endmodule
